rec_fn_lane_converter: RTL and testbench

Sequential, multi-lane, bidirectional converter between IEEE-754 (fN) and HardFloat recoded (recFN) formats. It accepts a packed vector of `numLanes` operands under a go/done handshake and converts them through one shared conversion datapath, one lane per cycle. The direction is chosen per transaction. It sits between Calyx memories that hold IEEE values and HardFloat arithmetic primitives, and replaces per-element instances of the single-lane combinational converter.

---
 rtl/rec_fn_lane_converter.sv | 252 +++++++++++++++++++++++++
 tb/tb_rec_fn_lane_converter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rec_fn_lane_converter.sv
// rec_fn_lane_converter
// Converts a packed vector of numLanes operands between IEEE-754 (fN) and
// HardFloat recoded (recFN) encodings. One shared conversion datapath is
// time-multiplexed over the lanes, one lane per cycle, under a go/done
// handshake. Results are staged in a result buffer and published to the
// outputs all at once, so a partially converted vector is never visible.
module rec_fn_lane_converter #(
  parameter int expWidth = 8,
  parameter int sigWidth = 24,
  parameter int numLanes = 4
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      go,
  input  logic                                      dir,
  input  logic [numLanes*(expWidth+sigWidth+1)-1:0] in_,
  output logic [numLanes*(expWidth+sigWidth+1)-1:0] out,
  output logic [numLanes-1:0]                       is_nan,
  output logic [numLanes-1:0]                       is_subnorm,
  output logic                                      done
);

  // Slot width (recFN width), exponent width and stored fraction width.
  localparam int W   = expWidth + sigWidth + 1;
  localparam int EW  = expWidth;
  localparam int FW  = sigWidth - 1;
  localparam int LCW = (numLanes > 1) ? $clog2(numLanes) : 1;

  // Offset between an IEEE biased exponent and the recoded exponent, and the
  // smallest recoded exponent that still maps to an IEEE normal number.
  localparam logic [EW:0]     REC_OFS   = (EW+1)'((2 ** (EW - 1)) + 1);
  localparam logic [EW:0]     MIN_NORM  = (EW+1)'((2 ** (EW - 1)) + 2);
  localparam logic [LCW-1:0]  LAST_LANE = LCW'(numLanes - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  // Leading-zero count of an IEEE fraction field (FW when the field is zero).
  // Scanning upward lets the highest set bit win.
  function automatic logic [EW:0] lead_zeros(input logic [FW-1:0] f);
    logic [EW:0] n;
    n = (EW+1)'(FW);
    for (int i = 0; i < FW; i++) begin
      n = f[i] ? (EW+1)'(FW - 1 - i) : n;
    end
    return n;
  endfunction

  // IEEE -> recoded. Result packing: {is_nan, is_subnorm, recFN value}.
  // Subnormals are normalised: the leading one is shifted out of the fraction
  // and the exponent is lowered by the shift distance.
  function automatic logic [W+1:0] fn_to_rec(input logic [W-2:0] v);
    logic          sign;
    logic [EW-1:0] e;
    logic [FW-1:0] f;
    logic [EW:0]   nd;
    logic [EW:0]   rexp;
    logic [FW-1:0] rf;
    logic          nan;
    logic          sub;
    sign = v[W-2];
    e    = v[W-3:FW];
    f    = v[FW-1:0];
    nd   = lead_zeros(f);
    nan  = (&e) & (|f);
    sub  = (~(|e)) & (|f);
    rf   = f;
    if (~(|e)) begin
      if (|f) begin
        rexp = REC_OFS - nd;
        rf   = f << (nd + (EW+1)'(1));
      end else begin
        rexp = {(EW+1){1'b0}};
      end
    end else if (&e) begin
      // 110 for infinity, 111 for NaN; the NaN payload rides in the fraction.
      rexp = {2'b11, |f, (EW-2)'(0)};
    end else begin
      rexp = {1'b0, e} + REC_OFS;
    end
    return {nan, sub, sign, rexp, rf};
  endfunction

  // Recoded -> IEEE. Result packing: {is_nan, is_subnorm, slot value} with the
  // slot's top bit held at zero.
  function automatic logic [W+1:0] rec_to_fn(input logic [W-1:0] v);
    logic          sign;
    logic [EW:0]   rexp;
    logic [FW-1:0] f;
    logic [EW-1:0] oexp;
    logic [FW-1:0] ofrac;
    logic [EW:0]   shamt;
    logic          nan;
    sign  = v[W-1];
    rexp  = v[W-2:FW];
    f     = v[FW-1:0];
    nan   = 1'b0;
    shamt = MIN_NORM - rexp;
    case (rexp[EW:EW-2])
      3'b000: begin
        oexp  = {EW{1'b0}};
        ofrac = {FW{1'b0}};
      end
      3'b110: begin
        oexp  = {EW{1'b1}};
        ofrac = {FW{1'b0}};
      end
      3'b111: begin
        oexp  = {EW{1'b1}};
        ofrac = f;
        nan   = 1'b1;
      end
      default: begin
        if (rexp < MIN_NORM) begin
          // Restore the hidden one and denormalise; large distances flush to 0.
          oexp  = {EW{1'b0}};
          ofrac = FW'({1'b1, f} >> shamt);
        end else begin
          oexp  = EW'(rexp - REC_OFS);
          ofrac = f;
        end
      end
    endcase
    return {nan, (~(|oexp)) & (|ofrac), 1'b0, sign, oexp, ofrac};
  endfunction

  state_e                 state_q, state_d;
  logic [LCW-1:0]         lane_cnt_q, lane_cnt_d;
  logic                   dir_q, dir_d;
  logic [numLanes*W-1:0]  op_q, op_d;
  logic [numLanes*W-1:0]  res_q, res_d;
  logic [numLanes-1:0]    res_nan_q, res_nan_d;
  logic [numLanes-1:0]    res_sub_q, res_sub_d;
  logic [numLanes*W-1:0]  out_q, out_d;
  logic [numLanes-1:0]    nan_q, nan_d;
  logic [numLanes-1:0]    sub_q, sub_d;
  logic                   done_q, done_d;

  logic [W-1:0]           lane_op_s;
  logic [W+1:0]           fwd_s;
  logic [W+1:0]           bwd_s;
  logic [W+1:0]           conv_s;

  // Select the buffered operand addressed by the lane counter.
  always_comb begin
    lane_op_s = {W{1'b0}};
    for (int i = 0; i < numLanes; i++) begin
      lane_op_s = (lane_cnt_q == LCW'(i)) ? op_q[i*W +: W] : lane_op_s;
    end
  end

  // Shared conversion datapath, steered by the direction latched at go.
  always_comb begin
    fwd_s  = fn_to_rec(lane_op_s[W-2:0]);
    bwd_s  = rec_to_fn(lane_op_s);
    conv_s = dir_q ? bwd_s : fwd_s;
  end

  // Next-state and buffer update logic for the IDLE/CONV/DONE sequencer.
  always_comb begin
    state_d    = state_q;
    lane_cnt_d = lane_cnt_q;
    dir_d      = dir_q;
    op_d       = op_q;
    res_d      = res_q;
    res_nan_d  = res_nan_q;
    res_sub_d  = res_sub_q;
    out_d      = out_q;
    nan_d      = nan_q;
    sub_d      = sub_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          op_d       = in_;
          dir_d      = dir;
          lane_cnt_d = {LCW{1'b0}};
          state_d    = CONV;
        end else begin
          state_d    = IDLE;
        end
      end
      CONV: begin
        for (int i = 0; i < numLanes; i++) begin
          if (lane_cnt_q == LCW'(i)) begin
            res_d[i*W +: W] = conv_s[W-1:0];
            res_nan_d[i]    = conv_s[W+1];
            res_sub_d[i]    = conv_s[W];
          end else begin
            res_d[i*W +: W] = res_q[i*W +: W];
            res_nan_d[i]    = res_nan_q[i];
            res_sub_d[i]    = res_sub_q[i];
          end
        end
        if (lane_cnt_q == LAST_LANE) begin
          state_d    = DONE;
        end else begin
          lane_cnt_d = lane_cnt_q + LCW'(1);
        end
      end
      DONE: begin
        // Publish the whole vector and its flags in the same edge as done.
        out_d   = res_q;
        nan_d   = res_nan_q;
        sub_d   = res_sub_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, buffer and output registers; reset aborts and clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      lane_cnt_q <= {LCW{1'b0}};
      dir_q      <= 1'b0;
      op_q       <= {(numLanes*W){1'b0}};
      res_q      <= {(numLanes*W){1'b0}};
      res_nan_q  <= {numLanes{1'b0}};
      res_sub_q  <= {numLanes{1'b0}};
      out_q      <= {(numLanes*W){1'b0}};
      nan_q      <= {numLanes{1'b0}};
      sub_q      <= {numLanes{1'b0}};
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_cnt_q <= lane_cnt_d;
      dir_q      <= dir_d;
      op_q       <= op_d;
      res_q      <= res_d;
      res_nan_q  <= res_nan_d;
      res_sub_q  <= res_sub_d;
      out_q      <= out_d;
      nan_q      <= nan_d;
      sub_q      <= sub_d;
      done_q     <= done_d;
    end
  end

  assign out        = out_q;
  assign is_nan     = nan_q;
  assign is_subnorm = sub_q;
  assign done       = done_q;

endmodule

// File: tb/tb_rec_fn_lane_converter.sv
// Testbench for rec_fn_lane_converter: 4-lane, 1-lane and 5-lane builds with
// default float widths, checked against a value-level reference model.
module tb_rec_fn_lane_converter;

  localparam int W = 33;

  logic             clk = 1'b0;
  logic             reset;
  logic             go4, dir4, done4;
  logic [4*W-1:0]   in4, out4;
  logic [3:0]       nan4, sub4;
  logic             go1, dir1, done1;
  logic [W-1:0]     in1, out1;
  logic [0:0]       nan1, sub1;
  logic             go5, dir5, done5;
  logic [5*W-1:0]   in5, out5;
  logic [4:0]       nan5, sub5;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rec_fn_lane_converter #(.expWidth(8), .sigWidth(24), .numLanes(4)) dut4 (
    .clk(clk), .reset(reset), .go(go4), .dir(dir4), .in_(in4),
    .out(out4), .is_nan(nan4), .is_subnorm(sub4), .done(done4));
  rec_fn_lane_converter #(.expWidth(8), .sigWidth(24), .numLanes(1)) dut1 (
    .clk(clk), .reset(reset), .go(go1), .dir(dir1), .in_(in1),
    .out(out1), .is_nan(nan1), .is_subnorm(sub1), .done(done1));
  rec_fn_lane_converter #(.expWidth(8), .sigWidth(24), .numLanes(5)) dut5 (
    .clk(clk), .reset(reset), .go(go5), .dir(dir5), .in_(in5),
    .out(out5), .is_nan(nan5), .is_subnorm(sub5), .done(done5));

  // Reference: IEEE single -> recoded, returns {nan, subnormal, recFN}.
  function automatic logic [34:0] m_fwd(input logic [31:0] x);
    logic [7:0]  e;
    logic [22:0] frac;
    logic [8:0]  rexp;
    int          nd;
    e    = x[30:23];
    frac = x[22:0];
    if (e == 8'h00 && frac == 23'h0) begin
      rexp = 9'h000;
    end else if (e == 8'h00) begin
      nd = 0;
      while (frac[22-nd] == 1'b0) nd++;
      rexp = 9'(129 - nd);
      frac = frac << (nd + 1);
    end else if (e == 8'hFF) begin
      rexp = (frac == 23'h0) ? 9'h180 : 9'h1C0;
    end else begin
      rexp = 9'(int'(e) + 129);
    end
    return {(e == 8'hFF) && (x[22:0] != 23'h0), (e == 8'h00) && (x[22:0] != 23'h0),
            x[31], rexp, frac};
  endfunction

  // Reference: recoded -> IEEE single via the unbiased exponent E = rexp-256.
  function automatic logic [34:0] m_bwd(input logic [32:0] r);
    logic [8:0]  rexp;
    logic [31:0] o;
    logic [63:0] sig;
    logic        nan;
    int          e_unb;
    rexp  = r[31:23];
    e_unb = int'(rexp) - 256;
    nan   = 1'b0;
    case (rexp[8:6])
      3'b000: o = {r[32], 8'h00, 23'h0};
      3'b110: o = {r[32], 8'hFF, 23'h0};
      3'b111: begin o = {r[32], 8'hFF, r[22:0]}; nan = 1'b1; end
      default: begin
        if (e_unb >= -126) begin
          o = {r[32], 8'(e_unb + 127), r[22:0]};
        end else begin
          sig = {40'h0, 1'b1, r[22:0]};
          sig = sig >> (-126 - e_unb);
          o   = {r[32], 8'h00, sig[22:0]};
        end
      end
    endcase
    return {nan, (o[30:23] == 8'h00) && (o[22:0] != 23'h0), 1'b0, o};
  endfunction

  // Reference over a whole packed vector of n lanes.
  function automatic void model_vec(input bit d, input logic [5*W-1:0] din, input int n,
                                    output logic [5*W-1:0] o, output logic [4:0] nn,
                                    output logic [4:0] ss);
    logic [34:0] r;
    o  = '0;
    nn = '0;
    ss = '0;
    for (int i = 0; i < n; i++) begin
      if (d) r = m_bwd(din[i*W +: W]);
      else   r = m_fwd(din[i*W +: 32]);
      o[i*W +: W] = r[32:0];
      nn[i]       = r[34];
      ss[i]       = r[33];
    end
  endfunction

  // Random IEEE pattern biased toward subnormals, specials and zeros.
  function automatic logic [31:0] rand_ieee();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 5))
      0: begin x[30:23] = 8'h00; x[22:0] = x[22:0] >> $urandom_range(0, 22); end
      1: begin x[30:23] = 8'hFF; if ($urandom_range(0, 2) == 0) x[22:0] = 23'h0; end
      2: x[30:0] = 31'h0;
      default: x = x;
    endcase
    return x;
  endfunction

  function automatic logic [5*W-1:0] rand_fn_vec(input int n);
    logic [5*W-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i*W +: W] = {1'b0, rand_ieee()};
    return v;
  endfunction

  function automatic logic [5*W-1:0] rand_rec_vec(input int n);
    logic [5*W-1:0] v;
    logic [34:0]    r;
    v = '0;
    for (int i = 0; i < n; i++) begin
      r = m_fwd(rand_ieee());
      v[i*W +: W] = r[32:0];
    end
    return v;
  endfunction

  // Drive one transaction into the selected build, scramble in_/dir after
  // acceptance, and wait (bounded) for done. lat = -1 if done never comes.
  task automatic run_txn(input int which, input bit d, input logic [5*W-1:0] din,
                         output int lat, output logic [5*W-1:0] dout,
                         output logic [4:0] dnan, output logic [4:0] dsub);
    logic seen;
    @(negedge clk);
    case (which)
      1:       begin go1 = 1'b1; dir1 = d; in1 = din[W-1:0]; end
      5:       begin go5 = 1'b1; dir5 = d; in5 = din; end
      default: begin go4 = 1'b1; dir4 = d; in4 = din[4*W-1:0]; end
    endcase
    @(posedge clk); #1;
    go1 = 1'b0; go4 = 1'b0; go5 = 1'b0;
    dir1 = ~d; dir4 = ~d; dir5 = ~d;
    in1 = ~din[W-1:0]; in4 = ~din[4*W-1:0]; in5 = ~din;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      case (which)
        1:       seen = done1;
        5:       seen = done5;
        default: seen = done4;
      endcase
      if (seen) begin lat = c; break; end
    end
    dout = '0; dnan = '0; dsub = '0;
    case (which)
      1:       begin dout[W-1:0] = out1; dnan[0] = nan1[0]; dsub[0] = sub1[0]; end
      5:       begin dout = out5; dnan = nan5; dsub = sub5; end
      default: begin dout[4*W-1:0] = out4; dnan[3:0] = nan4; dsub[3:0] = sub4; end
    endcase
  endtask

  task automatic test_reset();
    reset = 1'b1;
    go4 = 1'b0; go1 = 1'b0; go5 = 1'b0;
    dir4 = 1'b0; dir1 = 1'b0; dir5 = 1'b0;
    in4 = '0; in1 = '0; in5 = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({out4, nan4, sub4, done4} !== '0) begin
      n_bad++;
      $display("FAIL reset4: out=%h nan=%b sub=%b done=%b, required all 0", out4, nan4, sub4, done4);
    end
    n_vec++;
    if ({out1, nan1, sub1, done1, out5, nan5, sub5, done5} !== '0) begin
      n_bad++;
      $display("FAIL reset1_5: out1=%h done1=%b out5=%h done5=%b, required all 0", out1, done1, out5, done5);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [32:0]    ev [4];
    logic [31:0]    iv [4];
    logic [5*W-1:0] din, dout, exp_o;
    logic [4:0]     dn, ds;
    int             lat;
    iv = '{32'h3F800000, 32'h00000000, 32'h7F800000, 32'h7FC00000};
    ev = '{33'h080000000, 33'h000000000, 33'h0C0000000, 33'h0E0400000};
    din = '0; exp_o = '0;
    for (int i = 0; i < 4; i++) begin
      din[i*W +: W]   = {1'b0, iv[i]};
      exp_o[i*W +: W] = ev[i];
    end
    run_txn(4, 1'b0, din, lat, dout, dn, ds);
    n_vec++;
    if (lat !== 5) begin n_bad++; $display("FAIL directed_latency: got %0d, required 5", lat); end
    n_vec++;
    if (dout !== exp_o) begin n_bad++; $display("FAIL directed_out: got %h, required %h", dout, exp_o); end
    n_vec++;
    if (dn !== 5'b01000 || ds !== 5'b00000) begin
      n_bad++; $display("FAIL directed_flags: nan=%b sub=%b, required nan=01000 sub=00000", dn, ds);
    end
  endtask

  task automatic test_subnormal();
    logic [5*W-1:0] din, rec, back, exp_o;
    logic [4:0]     dn, ds, en, es;
    int             lat;
    din = rand_fn_vec(4);
    din[W-1:0] = 33'h000000001;
    model_vec(1'b0, din, 4, exp_o, en, es);
    run_txn(4, 1'b0, din, lat, rec, dn, ds);
    n_vec++;
    if (rec[W-1:0] !== 33'h035800000 || ds[0] !== 1'b1) begin
      n_bad++; $display("FAIL subnorm_fwd_lane0: got %h sub=%b, required 035800000 sub=1", rec[W-1:0], ds[0]);
    end
    n_vec++;
    if (lat !== 5 || rec !== exp_o || dn !== en || ds !== es) begin
      n_bad++; $display("FAIL subnorm_fwd_vec: lat=%0d out=%h, required lat=5 out=%h", lat, rec, exp_o);
    end
    run_txn(4, 1'b1, rec, lat, back, dn, ds);
    n_vec++;
    if (back[W-1:0] !== 33'h000000001 || ds[0] !== 1'b1) begin
      n_bad++; $display("FAIL subnorm_bwd_lane0: got %h sub=%b, required 000000001 sub=1", back[W-1:0], ds[0]);
    end
    n_vec++;
    if (lat !== 5 || back !== din) begin
      n_bad++; $display("FAIL subnorm_bwd_vec: lat=%0d out=%h, required lat=5 out=%h", lat, back, din);
    end
  endtask

  task automatic test_round_trip();
    logic [5*W-1:0] orig, rec, back, exp_o;
    logic [4:0]     dn, ds, en, es;
    int             lat;
    for (int t = 0; t < 250; t++) begin
      orig = rand_fn_vec(4);
      model_vec(1'b0, orig, 4, exp_o, en, es);
      run_txn(4, 1'b0, orig, lat, rec, dn, ds);
      n_vec++;
      if (lat !== 5 || rec !== exp_o || dn !== en || ds !== es) begin
        n_bad++;
        $display("FAIL roundtrip_fwd t=%0d: lat=%0d out=%h nan=%b sub=%b, required lat=5 out=%h nan=%b sub=%b",
                 t, lat, rec, dn, ds, exp_o, en, es);
      end
      run_txn(4, 1'b1, rec, lat, back, dn, ds);
      n_vec++;
      if (lat !== 5 || back !== orig || dn !== en || ds !== es) begin
        n_bad++;
        $display("FAIL roundtrip_bwd t=%0d: lat=%0d out=%h nan=%b sub=%b, required lat=5 out=%h nan=%b sub=%b",
                 t, lat, back, dn, ds, orig, en, es);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5*W-1:0] va, vb, vc, ea, eb, ec, exp_o;
    logic [4:0]     en, es;
    logic [4*W-1:0] prev;
    int             done_at [3];
    int             ndone;
    va = rand_fn_vec(4);
    vb = rand_rec_vec(4);
    vc = rand_fn_vec(4);
    model_vec(1'b0, va, 4, ea, en, es);
    model_vec(1'b1, vb, 4, eb, en, es);
    model_vec(1'b0, vc, 4, ec, en, es);
    ndone = 0;
    @(negedge clk);
    go4 = 1'b1; dir4 = 1'b0; in4 = va[4*W-1:0];
    prev = out4;
    for (int c = 0; c <= 24; c++) begin
      @(posedge clk); #1;
      if (c == 0)  begin in4 = vb[4*W-1:0]; dir4 = 1'b1; end
      if (c == 6)  begin in4 = vc[4*W-1:0]; dir4 = 1'b0; end
      if (c == 12) begin go4 = 1'b0; in4 = ~vc[4*W-1:0]; dir4 = 1'b1; end
      if (done4) begin
        exp_o = (ndone == 0) ? ea : ((ndone == 1) ? eb : ec);
        n_vec++;
        if (ndone > 2) begin
          n_bad++; $display("FAIL b2b_extra_done: done at cycle %0d, required only 3 pulses", c);
        end else begin
          done_at[ndone] = c;
          if (out4 !== exp_o[4*W-1:0]) begin
            n_bad++; $display("FAIL b2b_out%0d: got %h, required %h", ndone, out4, exp_o[4*W-1:0]);
          end
        end
        ndone++;
      end else if (out4 !== prev) begin
        n_vec++; n_bad++;
        $display("FAIL b2b_stable: out changed to %h without done at cycle %0d, required %h", out4, c, prev);
      end
      prev = out4;
    end
    n_vec++;
    if (ndone !== 3) begin
      n_bad++; $display("FAIL b2b_count: got %0d done pulses, required 3", ndone);
    end else if (done_at[0] !== 5 || done_at[1] !== 11 || done_at[2] !== 17) begin
      n_bad++; $display("FAIL b2b_spacing: done at %0d,%0d,%0d, required 5,11,17", done_at[0], done_at[1], done_at[2]);
    end
  endtask

  task automatic test_reset_mid();
    logic [5*W-1:0] din, dout, exp_o;
    logic [4:0]     dn, ds, en, es;
    int             lat;
    logic           saw;
    din = rand_fn_vec(4);
    @(negedge clk);
    go4 = 1'b1; dir4 = 1'b0; in4 = din[4*W-1:0];
    @(posedge clk); #1;
    go4 = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    saw = done4;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      saw = saw | done4;
    end
    n_vec++;
    if (saw !== 1'b0) begin n_bad++; $display("FAIL midreset_done: done seen=%b, required 0", saw); end
    n_vec++;
    if ({out4, nan4, sub4} !== '0) begin
      n_bad++; $display("FAIL midreset_out: out=%h nan=%b sub=%b, required all 0", out4, nan4, sub4);
    end
    model_vec(1'b0, din, 4, exp_o, en, es);
    run_txn(4, 1'b0, din, lat, dout, dn, ds);
    n_vec++;
    if (lat !== 5 || dout !== exp_o || dn !== en || ds !== es) begin
      n_bad++; $display("FAIL midreset_after: lat=%0d out=%h, required lat=5 out=%h", lat, dout, exp_o);
    end
  endtask

  task automatic test_lane_counts();
    logic [5*W-1:0] din, dout, exp_o;
    logic [4:0]     dn, ds, en, es;
    int             lat;
    bit             d;
    for (int t = 0; t < 6; t++) begin
      d   = t[0];
      din = d ? rand_rec_vec(1) : rand_fn_vec(1);
      model_vec(d, din, 1, exp_o, en, es);
      run_txn(1, d, din, lat, dout, dn, ds);
      n_vec++;
      if (lat !== 2 || dout !== exp_o || dn !== en || ds !== es) begin
        n_bad++; $display("FAIL lanes1 t=%0d: lat=%0d out=%h nan=%b, required lat=2 out=%h nan=%b",
                          t, lat, dout, dn, exp_o, en);
      end
      din = d ? rand_rec_vec(5) : rand_fn_vec(5);
      model_vec(d, din, 5, exp_o, en, es);
      run_txn(5, d, din, lat, dout, dn, ds);
      n_vec++;
      if (lat !== 6 || dout !== exp_o || dn !== en || ds !== es) begin
        n_bad++; $display("FAIL lanes5 t=%0d: lat=%0d out=%h nan=%b sub=%b, required lat=6 out=%h nan=%b sub=%b",
                          t, lat, dout, dn, ds, exp_o, en, es);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_subnormal();
    test_round_trip();
    test_back_to_back();
    test_reset_mid();
    test_lane_counts();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
